// File: rtl/line_unslider.sv
// Column un-slider: undoes the per-column rotate of the slide stage and
// rebuilds a NUM_COLS x COL_W block from serially received slid columns.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_COLLECT | accepting slid columns, col_idx_q selects the slot to fill
// S_OUTPUT  | block complete, held on out_block until out_ready
module line_unslider #(
  parameter int NUM_COLS   = 8,
  parameter int COL_W      = 8,
  parameter int SHIFT_STEP = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*COL_W-1:0]        in_column,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*COL_W-1:0] out_block,
  output logic                      out_error,
  output logic [NUM_COLS-1:0]       out_err_mask
);

  localparam int SW    = 2 * COL_W;
  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  typedef enum logic {S_COLLECT, S_OUTPUT} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            col_idx_q, col_idx_d;
  logic [NUM_COLS*COL_W-1:0]   block_q, block_d;
  logic [NUM_COLS-1:0]         mask_q, mask_d;
  int                          rot_amt;
  logic [SW-1:0]               col_rot;

  // A shift by SW yields zero, so rot_amt == 0 passes the column through.
  always_comb begin
    rot_amt = (SHIFT_STEP * int'(col_idx_q)) % SW;
    col_rot = (in_column >> rot_amt) | (in_column << (SW - rot_amt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_COLLECT;
      col_idx_q <= '0;
      block_q   <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      block_q   <= block_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    block_d   = block_q;
    mask_d    = mask_q;
    if (flush) begin
      // Abort discards any beat presented in the same cycle.
      state_d   = S_COLLECT;
      col_idx_d = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            block_d[col_idx_q*COL_W +: COL_W] = col_rot[COL_W-1:0];
            mask_d[col_idx_q]                 = |col_rot[SW-1:COL_W];
            if (col_idx_q == LAST_IDX) begin
              col_idx_d = '0;
              state_d   = S_OUTPUT;
            end else begin
              col_idx_d = col_idx_q + IDX_W'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (out_ready) state_d = S_COLLECT;
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  always_comb begin
    in_ready     = (state_q == S_COLLECT);
    out_valid    = (state_q == S_OUTPUT);
    out_block    = block_q;
    out_err_mask = mask_q;
    out_error    = |mask_q;
  end

endmodule

// File: tb/tb_line_unslider.sv
// Scoreboard bench for line_unslider: stimulus pushes expected blocks built
// from the original (unslid) columns, a monitor pops them on each handshake.
module tb_line_unslider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_column = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_block;
  logic        out_error;
  logic [7:0]  out_err_mask;

  int checks = 0;
  int failures = 0;
  int or_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random

  logic [71:0] exp_q[$];   // {mask, block}
  logic [63:0] pend_blk = '0;
  logic [7:0]  pend_mask = '0;
  int          pend_cnt = 0;

  line_unslider dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_column(in_column),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .out_error(out_error), .out_err_mask(out_err_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rotl(input logic [15:0] c, input int s);
    logic [31:0] w;
    w = {16'h0000, c} << s;
    return w[15:0] | w[31:16];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: sample after the negedge-driven inputs settle, well before posedge.
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !flush && out_valid) begin
        chk("in_ready_low_in_output", in_ready, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid: got block 0x%0h, expected no block", out_block);
        end else begin
          e = exp_q[0];
          chk("out_block", out_block, e[63:0]);
          chk("out_err_mask", out_err_mask, e[71:64]);
          chk("out_error", out_error, |e[71:64]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            @(posedge clk);
            #1;
            chk("in_ready_after_accept", in_ready, 1'b1);
            chk("out_valid_after_accept", out_valid, 1'b0);
          end
        end
      end
    end
  end

  // Present one beat; exp_lo/exp_err describe the column it should recover to.
  task automatic send_beat(input logic [15:0] beat, input logic [7:0] exp_lo,
                           input logic exp_err, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_column = 16'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b1;
    in_column = beat;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    pend_blk[pend_cnt*8 +: 8] = exp_lo;
    pend_mask[pend_cnt]       = exp_err;
    pend_cnt++;
    if (pend_cnt == 8) begin
      exp_q.push_back({pend_mask, pend_blk});
      pend_cnt = 0;
      chk("out_valid_latency", out_valid, 1'b1);
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_table(input logic [15:0] beats[8], input logic [7:0] lo[8],
                            input logic [7:0] errs, input int gap);
    for (int k = 0; k < 8; k++) send_beat(beats[k], lo[k], errs[k], gap);
    idle_inputs();
  endtask

  task automatic send_random_block(input int maxgap);
    logic [15:0] c;
    for (int k = 0; k < 8; k++) begin
      c = 16'($urandom);
      if ($urandom_range(0, 1) == 1) c[15:8] = 8'h00;
      send_beat(rotl(c, 2 * pend_cnt), c[7:0], |c[15:8], $urandom_range(0, maxgap));
    end
    idle_inputs();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Abort with a junk beat presented in the same cycle; use_rst selects rst.
  task automatic abort_with_beat(input bit use_rst);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    in_valid  = 1'b1;
    in_column = 16'($urandom);
    @(posedge clk);
    #1;
    pend_cnt = 0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    if (use_rst) begin
      chk("rst_out_block", out_block, 64'h0);
      chk("rst_out_err_mask", out_err_mask, 8'h00);
    end
    @(negedge clk);
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  logic [15:0] rt_beats[8] = '{16'h0001, 16'h0008, 16'h0030, 16'h0100,
                               16'h0500, 16'h1800, 16'h7000, 16'h0002};
  logic [7:0]  rt_lo[8]    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [15:0] wr_beats[8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hC03F};
  logic [7:0]  wr_lo[8]    = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'hFF};
  logic [15:0] er_beats[8] = '{16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [7:0]  zero_lo[8]  = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_block", out_block, 64'h0);
    chk("reset_out_err_mask", out_err_mask, 8'h00);
    chk("reset_out_error", out_error, 1'b0);

    or_mode = 0;
    send_table(rt_beats, rt_lo, 8'h00, 0);
    wait_drain();
    send_table(wr_beats, wr_lo, 8'h00, 0);
    wait_drain();
    send_table(er_beats, zero_lo, 8'h04, 0);
    wait_drain();
    send_table(rt_beats, rt_lo, 8'h00, 1);
    wait_drain();

    // Backpressure with junk presented while the block is held.
    or_mode = 1;
    send_table(rt_beats, rt_lo, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_column = 16'($urandom);
    end
    idle_inputs();
    or_mode = 0;
    wait_drain();
    send_table(wr_beats, wr_lo, 8'h00, 0);
    wait_drain();

    // Flush while a block is held and out_ready is high: block is dropped.
    or_mode = 1;
    send_random_block(0);
    or_mode = 0;
    abort_with_beat(1'b0);

    for (int k = 0; k < 3; k++) send_beat(rt_beats[k], rt_lo[k], 1'b0, 0);
    abort_with_beat(1'b0);
    send_table(rt_beats, rt_lo, 8'h00, 0);
    wait_drain();

    for (int k = 0; k < 3; k++) send_beat(rt_beats[k], rt_lo[k], 1'b0, 0);
    abort_with_beat(1'b1);
    send_table(rt_beats, rt_lo, 8'h00, 0);
    wait_drain();

    or_mode = 2;
    for (int b = 0; b < 30; b++) send_random_block(2);
    or_mode = 0;
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_unslider.md
Name: line_unslider

Overview:
Inverse of the column slide stage. Accepts slid 16-bit columns serially, one per handshake beat. Rotates column i right by 2*i to undo the slide and recovers the original 8-bit column. Once all 8 columns are collected, presents the rebuilt 64-bit block on a valid/ready output, with an error flag for any column whose upper byte was not zero after un-rotation.

Parameters:
NUM_COLS, 8, columns per block; (NUM_COLS-1)*SHIFT_STEP < 2*COL_W required
COL_W, 8, width of an original column; slid column width is 2*COL_W
SHIFT_STEP, 2, rotate distance per column index

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous abort of the partially collected block
in_valid  input  1  in_column holds a valid slid column
in_ready  output  1  block accepts a column this cycle
in_column  input  2*COL_W  slid column; beat k of a block is column k
out_valid  output  1  out_block/out_error/out_err_mask valid
out_ready  input  1  downstream accepts the block
out_block  output  NUM_COLS*COL_W  recovered columns; column k at bits [k*COL_W +: COL_W]
out_error  output  1  OR of out_err_mask
out_err_mask  output  NUM_COLS  bit k set if column k upper byte nonzero after un-rotation

Behaviour:
- States: COLLECT, OUTPUT. Counter col_idx (0..NUM_COLS-1).
- Reset (rst=1 at an edge): state=COLLECT, col_idx=0, out_valid=0, out_block=0, out_err_mask=0, out_error=0. in_ready=1 from the first cycle after reset.
- in_ready = (state==COLLECT), combinational from state only. It does not depend on in_valid.
- COLLECT, on beat (in_valid & in_ready):
  - r = in_column rotated right by SHIFT_STEP*col_idx, modulo 2*COL_W. Column 0 is unrotated.
  - out_block slot col_idx <= r[COL_W-1:0].
  - out_err_mask[col_idx] <= |r[2*COL_W-1:COL_W].
  - If col_idx<NUM_COLS-1: col_idx++.
  - Else: col_idx<=0, state<=OUTPUT, out_valid<=1 next cycle.
- COLLECT, no beat: no state change. Idle gaps between beats are allowed.
- OUTPUT:
  - out_valid=1; out_block and out_err_mask are stable; in_ready=0.
  - On out_ready=1: out_valid<=0, state<=COLLECT.
  - Latency: final beat at edge N -> out_valid=1 after edge N; accepted at edge M -> in_ready=1 after edge M.
  - No bypass, so minimum throughput is NUM_COLS+1 cycles per block.
- Slot registers are overwritten every block. No explicit clear between blocks is needed, because every slot and mask bit is rewritten before out_valid rises.
- flush=1 at an edge: col_idx<=0, state<=COLLECT, out_valid<=0. out_block and out_err_mask are left as-is (don't-care until the next out_valid).
  - flush with a simultaneous beat: flush wins and the beat is consumed and discarded.
  - flush in OUTPUT: the pending block is dropped, even if out_ready=1 in the same cycle.
- rst has priority over flush; both have priority over normal operation.
- out_error = |out_err_mask, combinational.

Test Plan:
- Round trip: beats 0x0001,0x0008,0x0030,0x0100,0x0500,0x1800,0x7000,0x0002 with out_ready=1 -> out_valid one cycle after the last beat, out_block=0x0807060504030201, out_err_mask=0x00, out_error=0.
- Wrap-around: column 7 beat 0xC03F (0xFF slid by 14), others 0x0000 -> out_block=0xFF00000000000000, out_error=0.
- Error detect: column 2 beat 0x0001 (un-rotates to 0x1000), others 0x0000 -> slot 2 = 0x00, out_err_mask=0x04, out_error=1.
- Backpressure: block complete, out_ready=0 for 5 cycles while in_valid=1 with junk -> out_valid held, out_block unchanged, in_ready=0, col_idx stays 0; out_ready=1 -> out_valid drops, in_ready=1 next cycle.
- Gapped input: in_valid toggles 1/0 across 16 cycles with the round-trip data -> same result as the round-trip case; idle cycles do not advance col_idx.
- Abort: 3 beats accepted, then flush (and separately rst) asserted alongside a beat -> that beat is discarded; the next 8 beats of round-trip data give out_block=0x0807060504030201.
